// File: rtl/minhash_kmer_selector_pkg.sv
// Shared types for the minhash k-mer selector: FSM states, table entry, hash defaults.
package proj_pkg;
    localparam int HASH_LEN = 16;
    localparam logic [HASH_LEN-1:0] HASH_SEED = 16'h9E37;
    localparam int ACTUAL_MEM = 32;
    localparam int INDICE_LEN = $clog2(ACTUAL_MEM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Table entry widths follow the package defaults; the top's INDICE_LEN/HASH_LEN must match.
    typedef struct packed {
        logic                  valid;
        logic [INDICE_LEN-1:0] index;
        logic [HASH_LEN-1:0]   hash;
    } entry_t;
endpackage

// File: rtl/minhash_kmer_selector_kmer_hash.sv
// Combinational multiplicative k-mer hash: word * HASH_SEED, truncated to HASH_LEN.
module kmer_hash #(
    parameter int                  KMER_LEN  = 4,
    parameter int                  BASE_LEN  = 4,
    parameter int                  HASH_LEN  = 16,
    parameter logic [HASH_LEN-1:0] HASH_SEED = 16'h9E37
) (
    input  logic [KMER_LEN*BASE_LEN-1:0] kmer_word,
    output logic [HASH_LEN-1:0]          hash
);
    localparam int WORD_W = KMER_LEN*BASE_LEN;

    logic [WORD_W+HASH_LEN-1:0] prod;

    assign prod = {{HASH_LEN{1'b0}}, kmer_word} * {{WORD_W{1'b0}}, HASH_SEED};
    assign hash = prod[HASH_LEN-1:0];
endmodule

// File: rtl/minhash_kmer_selector.sv
// Scans memory one k-mer per clock and keeps the INDICES_COUNT smallest hashes, sorted.
// Optional: define MINHASH_SKIP_N_EN to drop k-mers containing an 'N' (4'h0) base.
module minhash_kmer_selector
    import proj_pkg::*;
#(
    parameter int                  KMER_LEN      = 4,
    parameter int                  BASE_LEN      = 4,
    parameter int                  ACTUAL_MEM    = 32,
    parameter int                  MEM_LEN       = ACTUAL_MEM*BASE_LEN,
    parameter int                  INDICES_COUNT = 2,
    parameter int                  INDICE_LEN    = $clog2(ACTUAL_MEM),
    parameter int                  HASH_LEN      = proj_pkg::HASH_LEN,
    parameter logic [HASH_LEN-1:0] HASH_SEED     = proj_pkg::HASH_SEED,
    parameter int                  CNT_LEN       = $clog2(INDICES_COUNT+1)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [MEM_LEN-1:0]                      memory,
    output logic                                    busy,
    output logic                                    done,
    output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] kmer_indices,
    output logic [CNT_LEN-1:0]                      valid_count
);
    localparam int NUM_KMERS = ACTUAL_MEM-KMER_LEN+1;
    localparam logic [INDICE_LEN-1:0] POS_LAST = INDICE_LEN'(NUM_KMERS-1);

    state_t state, state_nxt;

    logic [INDICE_LEN-1:0]          pos;
    logic [KMER_LEN*BASE_LEN-1:0]   kmer_word;
    logic [HASH_LEN-1:0]            hash_c;
    logic                           keep_c;
    logic                           start_acc;

    logic                           s1_vld;
    logic                           s1_keep;
    logic [INDICE_LEN-1:0]          s1_idx;
    logic [HASH_LEN-1:0]            s1_hash;

    entry_t [INDICES_COUNT-1:0]     tab, tab_nxt;
    entry_t                         ent_new;
    logic   [INDICES_COUNT-1:0]     lt;

    assign start_acc = (state == ST_IDLE) && start;
    assign kmer_word = memory[int'(pos)*BASE_LEN +: KMER_LEN*BASE_LEN];

    kmer_hash #(
        .KMER_LEN (KMER_LEN),
        .BASE_LEN (BASE_LEN),
        .HASH_LEN (HASH_LEN),
        .HASH_SEED(HASH_SEED)
    ) u_hash (
        .kmer_word(kmer_word),
        .hash     (hash_c)
    );

`ifdef MINHASH_SKIP_N_EN
    always_comb begin
        keep_c = 1'b1;
        for (int b = 0; b < KMER_LEN; b++)
            if (kmer_word[b*BASE_LEN +: BASE_LEN] == '0) keep_c = 1'b0;
    end
`else
    assign keep_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_SCAN;
            end
            ST_SCAN:  if (pos == POS_LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stage 1: position counter and registered {pos, hash, keep}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            s1_vld  <= 1'b0;
            s1_keep <= 1'b0;
            s1_idx  <= '0;
            s1_hash <= '0;
        end else if (start_acc) begin
            pos    <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= (state == ST_SCAN);
            if (state == ST_SCAN) begin
                pos     <= pos + 1'b1;
                s1_keep <= keep_c;
                s1_idx  <= pos;
                s1_hash <= hash_c;
            end
        end
    end

    // Stage 2: sorted insert. lt is monotonic because valid slots stay packed and sorted.
    assign ent_new = {1'b1, s1_idx, s1_hash};

    genvar g;
    generate
        for (g = 0; g < INDICES_COUNT; g++) begin : g_slot
            assign lt[g] = !tab[g].valid || (tab[g].hash > s1_hash);
            if (g == 0) begin : g_head
                assign tab_nxt[g] = lt[g] ? ent_new : tab[g];
            end else begin : g_body
                assign tab_nxt[g] = lt[g] ? (lt[g-1] ? tab[g-1] : ent_new) : tab[g];
            end
            assign kmer_indices[g] = tab[g].valid ? tab[g].index : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  tab <= '0;
        else if (start_acc)          tab <= '0;
        else if (s1_vld && s1_keep)  tab <= tab_nxt;
    end

    always_comb begin
        valid_count = '0;
        for (int i = 0; i < INDICES_COUNT; i++)
            valid_count = valid_count + CNT_LEN'(tab[i].valid);
    end
endmodule

// File: tb/tb_minhash_kmer_selector.sv
// Scoreboard bench for minhash_kmer_selector: driver queues expected results, monitor checks on done.
module tb_minhash_kmer_selector;
    localparam int NUM_KMERS = 29;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [127:0]     mem;
    logic             busy;
    logic             done;
    logic [1:0][4:0]  kmer_indices;
    logic [1:0]       valid_count;

    typedef struct {
        logic [4:0] i0;
        logic [4:0] i1;
        logic [1:0] cnt;
        int         dcyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    minhash_kmer_selector #(
        .HASH_SEED(16'h0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .memory      (mem),
        .busy        (busy),
        .done        (done),
        .kmer_indices(kmer_indices),
        .valid_count (valid_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("stray_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.dcyc);
                chk("slot0", kmer_indices[0], e.i0);
                chk("slot1", kmer_indices[1], e.i1);
                chk("valid_count", valid_count, e.cnt);
            end
        end
    end

    task automatic fill(input logic [3:0] v);
        for (int p = 0; p < 32; p++) mem[p*4 +: 4] = v;
    endtask

    task automatic pulse_start(input bit push, input logic [4:0] i0, input logic [4:0] i1,
                               input logic [1:0] cnt, output int c);
        exp_t e;
        @(negedge clk);
        c = cyc;
        start = 1'b1;
        if (push) begin
            e.i0 = i0; e.i1 = i1; e.cnt = cnt; e.dcyc = c + NUM_KMERS + 2;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic check_idle(input string tag, input logic [4:0] i0, input logic [4:0] i1,
                              input logic [1:0] cnt);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_slot0"}, kmer_indices[0], i0);
        chk({tag, "_hold_slot1"}, kmer_indices[1], i1);
        chk({tag, "_hold_count"}, valid_count, cnt);
    endtask

    task automatic mem_t2();
        fill(4'hF);
        for (int p = 5; p <= 8; p++) mem[p*4 +: 4] = 4'h3;
        for (int p = 20; p <= 23; p++) mem[p*4 +: 4] = 4'h2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        fill(4'h1);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_slot0", kmer_indices[0], 0);
        chk("rst_slot1", kmer_indices[1], 0);
        chk("rst_count", valid_count, 0);
        rst_n = 1'b1;

        // All-equal hashes: ties keep the earliest positions.
        fill(4'h1);
        pulse_start(1'b1, 5'd0, 5'd1, 2'd2, c0);
        chk("busy_after_start", busy, 1);
        wait_idle();
        check_idle("t1", 5'd0, 5'd1, 2'd2);

        // Distinct minima at 20 (16'h2222) and 19 (16'h222F).
        mem_t2();
        pulse_start(1'b1, 5'd20, 5'd19, 2'd2, c0);
        wait_idle();
        check_idle("t2", 5'd20, 5'd19, 2'd2);

        // Leading 'N' base.
        fill(4'h1);
        mem[3:0] = 4'h0;
`ifdef MINHASH_SKIP_N_EN
        pulse_start(1'b1, 5'd1, 5'd2, 2'd2, c0);
        wait_idle();
        check_idle("t3", 5'd1, 5'd2, 2'd2);
`else
        pulse_start(1'b1, 5'd0, 5'd1, 2'd2, c0);
        wait_idle();
        check_idle("t3", 5'd0, 5'd1, 2'd2);
`endif

        // Start pulses during SCAN and DONE are ignored.
        fill(4'h1);
        pulse_start(1'b1, 5'd0, 5'd1, 2'd2, c0);
        while (cyc < c0 + 5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + NUM_KMERS + 2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        check_idle("t4", 5'd0, 5'd1, 2'd2);

        // Async reset mid-scan discards the partial table.
        mem_t2();
        pulse_start(1'b0, 5'd0, 5'd0, 2'd0, c0);
        while (cyc < c0 + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_slot0", kmer_indices[0], 0);
        chk("mid_rst_slot1", kmer_indices[1], 0);
        chk("mid_rst_count", valid_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start(1'b1, 5'd20, 5'd19, 2'd2, c0);
        wait_idle();
        check_idle("t5", 5'd20, 5'd19, 2'd2);

        // Back-to-back: start in the first IDLE cycle after done.
        pulse_start(1'b1, 5'd20, 5'd19, 2'd2, c0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("b2b_done_timeout", 1, 0);
        pulse_start(1'b1, 5'd20, 5'd19, 2'd2, c0);
        wait_idle();
        check_idle("t6", 5'd20, 5'd19, 2'd2);

        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
